tl_a_fifo: RTL and testbench
============================

// Module: tl_a_fifo
// PURPOSE
//  Parametrised TL-UL A-channel buffer: elastic FIFO between an upstream A master and a
//  downstream A slave, generalising the single-stage A-channel hookup to DEPTH entries.
//  Adds occupancy status and a sticky protocol-error monitor on accepted beats.
//  Sits between the core LSU/fetch A port and the crossbar, or in front of slow peripherals.
// PARAMETERS
//  DEPTH      4   number of buffered beats, >=1, need not be a power of two
//  CHECK_ERR  1   1: protocol monitor present; 0: err tied 0, err_clr ignored
// PORTS
//  clock    in   1     single clock; all state on posedge
//  reset    in   1     asynchronous, active-low reset
//  up       tl_a_intf.slave   A beats from upstream master (valid/ready/opcode..corrupt)
//  dn       tl_a_intf.master  A beats toward downstream slave
//  count    out  $clog2(DEPTH+1)  current occupancy
//  full     out  1     count==DEPTH
//  empty    out  1     count==0
//  err      out  1     sticky: an accepted beat violated TL-UL A rules
//  err_clr  in   1     synchronous clear of err
// BEHAVIOUR
//  - Reset (async assert): count=0, wr/rd ptr=0, dn.valid=0, err=0, full=0, empty=1;
//    stored beats discarded; dn.valid drops immediately, not at next edge.
//  - up.ready = !full (registered-state only; no combinational path from dn.ready).
//  - push = up.valid&up.ready; pop = dn.valid&dn.ready; beat = {opcode,param,size,
//    source,address,mask,data,corrupt}, stored whole, payload unmodified.
//  - dn.valid = !empty; dn payload = entry at rd ptr (registered storage output).
//  - Min latency up->dn: 1 cycle. Throughput 1 beat/cycle when not full.
//  - push&pop same cycle: count unchanged, both ptrs advance; legal at any count<DEPTH;
//    when full, push cannot occur (ready=0), pop alone frees one slot next cycle.
//  - Ptrs wrap DEPTH-1 -> 0 (explicit compare, not modulo power of two).
//  - dn payload stable while dn.valid&!dn.ready (TL rule); never changes under stall.
//  - Monitor (CHECK_ERR=1), evaluated on push: err<=1 if param!=0, or opcode not in
//    {PutFullData,PutPartialData,Get}, or address[size-1:0]!=0 (misaligned), or
//    PutFullData mask != full-lane mask for size/address. Beat still enqueued.
//  - err_clr&&error-on-same-push: set wins (err stays 1).
// CONFIGURATION
//  TL_A_FIFO_BYPASS_EN defined: when empty && up.valid && dn.ready, beat flows up->dn
//    combinationally same cycle, not written, count stays 0; dn.valid=up.valid when empty.
//    up.ready still = !full. Monitor still checks bypassed beats.
//  Not defined: strict 1-cycle minimum latency; dn.* driven only from storage.
// STRUCTURE
//  - tilelink_pkg: add packed struct tl_a_beat_t (all A payload fields) and function
//    tl_a_lane_mask(size,addr_lsbs) returning expected full mask; reuse TL_* widths,
//    tl_a_opcode_e.
//  - Sub-module tl_fifo_mem: DEPTH x $bits(tl_a_beat_t) register array, write port +
//    registered-address read; no reset on data (ptrs/count reset in tl_a_fifo).
// TESTING
//  1 DEPTH=4, push 4 Gets src 0..3 with dn.ready=0 -> full=1, up.ready=0, count=4;
//    then dn.ready=1 -> beats exit src 0,1,2,3 in order, empty after 4 cycles.
//  2 DEPTH=3, continuous push+pop 10 beats at count=2 -> count stays 2, ptr wrap 2->0
//    seen, no beat lost/duplicated (scoreboard).
//  3 Stall: dn.ready=0 for 5 cycles with dn.valid=1 -> dn payload bit-identical all cycles.
//  4 Push Get size=2 address=0x1002 -> err=1 next cycle; err_clr=1 -> err=0; err_clr with
//    simultaneous bad push (param=3) -> err stays 1.
//  5 Assert reset mid-traffic with count=2 -> dn.valid=0 immediately, count=0; after
//    release first new beat appears at dn 1 cycle after push (bypass off).
//  6 TL_A_FIFO_BYPASS_EN, empty, dn.ready=1, push Put addr 0x40 -> dn.valid same cycle,
//    count stays 0.

Source files
------------

// File: rtl/tilelink_pkg.sv
// TL-UL A-channel types, widths and helpers shared by the A-channel buffer and its users.
package tilelink_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_LGW = $clog2(TL_DBW);
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_PW  = 3;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_opcode_e;

    typedef struct packed {
        tl_a_opcode_e        opcode;
        logic [TL_PW-1:0]    param;
        logic [TL_SZW-1:0]   size;
        logic [TL_AIW-1:0]   source;
        logic [TL_AW-1:0]    address;
        logic [TL_DBW-1:0]   mask;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_a_beat_t;

    // Lanes covered by a naturally aligned 2^size-byte access; sizes wider than the bus cover all lanes.
    function automatic logic [TL_DBW-1:0] tl_a_lane_mask(input logic [TL_SZW-1:0] size,
                                                         input logic [TL_LGW-1:0] addr_lsbs);
        logic [TL_DBW-1:0] m;
        m = '0;
        for (int i = 0; i < TL_DBW; i++) begin
            if ((i >> size) == (int'(addr_lsbs) >> size)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tl_a_intf.sv
// TL-UL A channel bundle: master drives valid and payload, slave drives ready.
interface tl_a_intf;
    import tilelink_pkg::*;

    logic                valid;
    logic                ready;
    tl_a_opcode_e        opcode;
    logic [TL_PW-1:0]    param;
    logic [TL_SZW-1:0]   size;
    logic [TL_AIW-1:0]   source;
    logic [TL_AW-1:0]    address;
    logic [TL_DBW-1:0]   mask;
    logic [TL_DW-1:0]    data;
    logic                corrupt;

    modport master (output valid, opcode, param, size, source, address, mask, data, corrupt,
                    input  ready);
    modport slave  (input  valid, opcode, param, size, source, address, mask, data, corrupt,
                    output ready);

endinterface

// File: rtl/tl_fifo_mem.sv
// Beat storage for the A-channel buffer: one write port, read addressed by the registered read pointer.
module tl_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tl_a_fifo.sv
// DEPTH-entry elastic buffer on a TL-UL A channel with occupancy status and a sticky protocol monitor.
// Define TL_A_FIFO_BYPASS_EN to let a beat cut through combinationally when the buffer is empty.
module tl_a_fifo
    import tilelink_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CHECK_ERR = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    tl_a_intf.slave                    up,
    tl_a_intf.master                   dn,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err,
    input  logic                       err_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr, rd_ptr;
    tl_a_beat_t    up_beat, mem_beat, dn_beat;
    logic          push, bypass, wr_en, rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign up.ready = !full;
    assign push     = up.valid && !full;

    assign up_beat = '{opcode:  up.opcode,  param:   up.param,
                       size:    up.size,    source:  up.source,
                       address: up.address, mask:    up.mask,
                       data:    up.data,    corrupt: up.corrupt};

`ifdef TL_A_FIFO_BYPASS_EN
    assign bypass   = empty && up.valid && dn.ready;
    assign dn.valid = empty ? up.valid : 1'b1;
    assign dn_beat  = empty ? up_beat : mem_beat;
`else
    assign bypass   = 1'b0;
    assign dn.valid = !empty;
    assign dn_beat  = mem_beat;
`endif

    // A bypassed beat is consumed downstream in the same cycle, so it never touches storage.
    assign wr_en = push && !bypass;
    assign rd_en = !empty && dn.ready;

    assign dn.opcode  = dn_beat.opcode;
    assign dn.param   = dn_beat.param;
    assign dn.size    = dn_beat.size;
    assign dn.source  = dn_beat.source;
    assign dn.address = dn_beat.address;
    assign dn.mask    = dn_beat.mask;
    assign dn.data    = dn_beat.data;
    assign dn.corrupt = dn_beat.corrupt;

    tl_fifo_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(tl_a_beat_t))
    ) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (up_beat),
        .raddr (rd_ptr),
        .rdata (mem_beat)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    generate
        if (CHECK_ERR != 0) begin : g_mon
            logic             beat_bad;
            logic [TL_AW-1:0] align_mask;

            always_comb begin
                align_mask = (TL_AW'(1) << up.size) - TL_AW'(1);
                beat_bad   = 1'b0;
                if (up.param != '0) beat_bad = 1'b1;
                if (!(up.opcode inside {PutFullData, PutPartialData, Get})) beat_bad = 1'b1;
                if ((up.address & align_mask) != '0) beat_bad = 1'b1;
                if (up.opcode == PutFullData &&
                    up.mask != tl_a_lane_mask(up.size, up.address[TL_LGW-1:0])) beat_bad = 1'b1;
            end

            // Setting takes priority so a clear cannot hide an error arriving in the same cycle.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    err <= 1'b0;
                end else if (push && beat_bad) begin
                    err <= 1'b1;
                end else if (err_clr) begin
                    err <= 1'b0;
                end
            end
        end else begin : g_nomon
            logic unused_err_clr;
            assign unused_err_clr = err_clr;
            assign err            = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_tl_a_fifo.sv
// Directed bench for tl_a_fifo: a DEPTH=4 monitored buffer and a DEPTH=3 buffer without monitor.
module tb_tl_a_fifo;
    import tilelink_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] count4;
    logic [1:0] count3;
    logic       full4, empty4, err4, err_clr4;
    logic       full3, empty3, err3, err_clr3;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    tl_a_intf up4();
    tl_a_intf dn4();
    tl_a_intf up3();
    tl_a_intf dn3();

    always #5 clock = ~clock;

    tl_a_fifo #(.DEPTH(4), .CHECK_ERR(1)) u_dut4 (
        .clock(clock), .reset(reset), .up(up4), .dn(dn4),
        .count(count4), .full(full4), .empty(empty4), .err(err4), .err_clr(err_clr4)
    );

    tl_a_fifo #(.DEPTH(3), .CHECK_ERR(0)) u_dut3 (
        .clock(clock), .reset(reset), .up(up3), .dn(dn3),
        .count(count3), .full(full3), .empty(empty3), .err(err3), .err_clr(err_clr3)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tl_a_beat_t mk(input tl_a_opcode_e op, input logic [2:0] prm,
                                      input logic [1:0] sz, input logic [7:0] src,
                                      input logic [31:0] addr, input logic [3:0] msk,
                                      input logic [31:0] dat);
        return '{opcode: op, param: prm, size: sz, source: src, address: addr,
                 mask: msk, data: dat, corrupt: 1'b0};
    endfunction

    function automatic tl_a_beat_t payload4();
        return '{opcode: dn4.opcode, param: dn4.param, size: dn4.size, source: dn4.source,
                 address: dn4.address, mask: dn4.mask, data: dn4.data, corrupt: dn4.corrupt};
    endfunction

    task automatic drive4(input tl_a_beat_t b);
        up4.valid   = 1'b1;
        up4.opcode  = b.opcode;
        up4.param   = b.param;
        up4.size    = b.size;
        up4.source  = b.source;
        up4.address = b.address;
        up4.mask    = b.mask;
        up4.data    = b.data;
        up4.corrupt = b.corrupt;
    endtask

    task automatic drive3(input logic [7:0] src, input logic [2:0] prm);
        up3.valid   = 1'b1;
        up3.opcode  = Get;
        up3.param   = prm;
        up3.size    = 2'd2;
        up3.source  = src;
        up3.address = {22'd0, src, 2'b00};
        up3.mask    = 4'hF;
        up3.data    = {24'd0, src};
        up3.corrupt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        up4.valid = 1'b0; up4.opcode = Get; up4.param = '0; up4.size = '0; up4.source = '0;
        up4.address = '0; up4.mask = '0; up4.data = '0; up4.corrupt = 1'b0;
        up3.valid = 1'b0; up3.opcode = Get; up3.param = '0; up3.size = '0; up3.source = '0;
        up3.address = '0; up3.mask = '0; up3.data = '0; up3.corrupt = 1'b0;
        dn4.ready = 1'b0; dn3.ready = 1'b0;
        err_clr4 = 1'b0; err_clr3 = 1'b0;

        // reset state
        @(negedge clock);
        check("rst_count", 128'(count4), 128'(0));
        check("rst_empty", 128'(empty4), 128'(1));
        check("rst_full", 128'(full4), 128'(0));
        check("rst_dn_valid", 128'(dn4.valid), 128'(0));
        check("rst_err", 128'(err4), 128'(0));
        check("rst_up_ready", 128'(up4.ready), 128'(1));
        check("rst_count3", 128'(count3), 128'(0));
        reset = 1'b1;

        // fill DEPTH=4 with downstream stalled
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive4(mk(Get, 3'd0, 2'd2, 8'(i), 32'h100 + 32'(4 * i), 4'hF, 32'hA000 + 32'(i)));
        end
        @(negedge clock);
        up4.valid = 1'b0;
        check("fill_count", 128'(count4), 128'(4));
        check("fill_full", 128'(full4), 128'(1));
        check("fill_up_ready", 128'(up4.ready), 128'(0));

        // stall: head beat held while an extra upstream beat is refused
        for (int k = 0; k < 5; k++) begin
            drive4(mk(PutFullData, 3'd0, 2'd2, 8'h77, 32'h200, 4'hF, 32'hDEAD));
            check("stall_valid", 128'(dn4.valid), 128'(1));
            check("stall_payload", 128'(payload4()),
                  128'(mk(Get, 3'd0, 2'd2, 8'd0, 32'h100, 4'hF, 32'hA000)));
            @(negedge clock);
        end
        up4.valid = 1'b0;
        check("stall_count", 128'(count4), 128'(4));

        // drain in order
        dn4.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_payload", 128'(payload4()),
                  128'(mk(Get, 3'd0, 2'd2, 8'(k), 32'h100 + 32'(4 * k), 4'hF, 32'hA000 + 32'(k))));
            @(negedge clock);
        end
        check("drain_empty", 128'(empty4), 128'(1));
        check("drain_dn_valid", 128'(dn4.valid), 128'(0));
        dn4.ready = 1'b0;

        // DEPTH=3 streaming at count=2 with scoreboard
        drive3(8'd10, 3'd0); exp_q.push_back(8'd10);
        @(negedge clock);
        drive3(8'd11, 3'd0); exp_q.push_back(8'd11);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stream_count", 128'(count3), 128'(2));
            check("stream_src", 128'(dn3.source), 128'(exp_q.pop_front()));
            drive3(8'(12 + i), (i == 5) ? 3'd3 : 3'd0);
            exp_q.push_back(8'(12 + i));
            dn3.ready = 1'b1;
        end
        @(negedge clock);
        up3.valid = 1'b0;
        check("stream_count_end", 128'(count3), 128'(2));
        check("stream_src", 128'(dn3.source), 128'(exp_q.pop_front()));
        @(negedge clock);
        check("stream_src", 128'(dn3.source), 128'(exp_q.pop_front()));
        @(negedge clock);
        check("stream_empty", 128'(empty3), 128'(1));
        check("stream_dn_valid", 128'(dn3.valid), 128'(0));
        check("nomon_err", 128'(err3), 128'(0));
        dn3.ready = 1'b0;

        // protocol monitor
        drive4(mk(Get, 3'd0, 2'd2, 8'd1, 32'h1002, 4'hF, 32'd0));
        @(negedge clock);
        up4.valid = 1'b0;
        check("mis_err", 128'(err4), 128'(1));
        check("mis_enq_valid", 128'(dn4.valid), 128'(1));
        check("mis_enq_addr", 128'(dn4.address), 128'(32'h1002));
        err_clr4 = 1'b1;
        @(negedge clock);
        check("clr_err", 128'(err4), 128'(0));
        drive4(mk(Get, 3'd3, 2'd2, 8'd2, 32'h2000, 4'hF, 32'd0));
        @(negedge clock);
        up4.valid = 1'b0;
        err_clr4 = 1'b0;
        check("set_wins", 128'(err4), 128'(1));
        err_clr4 = 1'b1;
        @(negedge clock);
        err_clr4 = 1'b0;
        check("clr2_err", 128'(err4), 128'(0));
        drive4(mk(PutPartialData, 3'd0, 2'd0, 8'd3, 32'h3, 4'b1000, 32'h11000000));
        @(negedge clock);
        up4.valid = 1'b0;
        check("ppd_ok_err", 128'(err4), 128'(0));
        drive4(mk(PutFullData, 3'd0, 2'd1, 8'd4, 32'h2, 4'b0011, 32'h0));
        @(negedge clock);
        up4.valid = 1'b0;
        check("pfd_mask_err", 128'(err4), 128'(1));
        check("mon_count", 128'(count4), 128'(4));
        dn4.ready = 1'b1;
        repeat (4) @(negedge clock);
        check("mon_drain_empty", 128'(empty4), 128'(1));
        dn4.ready = 1'b0;
        err_clr4 = 1'b1;
        @(negedge clock);
        err_clr4 = 1'b0;

        // asynchronous reset mid-traffic
        drive4(mk(Get, 3'd0, 2'd2, 8'h30, 32'h300, 4'hF, 32'd0));
        @(negedge clock);
        drive4(mk(Get, 3'd0, 2'd2, 8'h31, 32'h304, 4'hF, 32'd0));
        @(negedge clock);
        up4.valid = 1'b0;
        check("pre_rst_count", 128'(count4), 128'(2));
        check("pre_rst_valid", 128'(dn4.valid), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 128'(dn4.valid), 128'(0));
        check("async_rst_count", 128'(count4), 128'(0));
        check("async_rst_empty", 128'(empty4), 128'(1));
        @(negedge clock);
        reset = 1'b1;
`ifndef TL_A_FIFO_BYPASS_EN
        @(negedge clock);
        drive4(mk(Get, 3'd0, 2'd2, 8'h55, 32'h500, 4'hF, 32'd0));
        dn4.ready = 1'b1;
        #1;
        check("lat_same_cycle", 128'(dn4.valid), 128'(0));
        @(negedge clock);
        check("lat_next_valid", 128'(dn4.valid), 128'(1));
        check("lat_next_src", 128'(dn4.source), 128'(8'h55));
        up4.valid = 1'b0;
        @(negedge clock);
        check("lat_drain_empty", 128'(empty4), 128'(1));
        dn4.ready = 1'b0;
`else
        // combinational cut-through when empty
        @(negedge clock);
        dn4.ready = 1'b1;
        drive4(mk(PutFullData, 3'd0, 2'd2, 8'd6, 32'h40, 4'hF, 32'hCAFE));
        #1;
        check("byp_valid", 128'(dn4.valid), 128'(1));
        check("byp_addr", 128'(dn4.address), 128'(32'h40));
        check("byp_count", 128'(count4), 128'(0));
        @(negedge clock);
        up4.valid = 1'b0;
        #1;
        check("byp_count_after", 128'(count4), 128'(0));
        check("byp_valid_after", 128'(dn4.valid), 128'(0));
        check("byp_err", 128'(err4), 128'(0));
        dn4.ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
